// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks the 4:1 mux select through channels A..D, dwells
// DWELL cycles on each, samples y on the last dwell cycle and publishes the
// four samples as `word` with a one-cycle `done` pulse. Sweeps are
// single-shot (mode=0) or back-to-back (mode=1).
// Optional feature macro: MUX_SCAN_PARITY_EN adds a registered `parity`
// output equal to the XOR of `word`.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 2,
  parameter int unsigned CW    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       y,
  output logic       sel1,
  output logic       sel2,
  output logic       sample,
  output logic       busy,
  output logic       done,
  output logic [3:0] word
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       parity
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  // DWELL=0 is illegal and behaves as DWELL=1.
  localparam int unsigned      DW_EFF   = (DWELL == 0) ? 1 : DWELL;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DW_EFF - 1);

  logic [0:0]    state;
  logic [1:0]    ch;
  logic [CW-1:0] cnt;
  // Only channels A..C need shadowing: channel D is taken straight from y
  // at the sweep-end edge, so a fourth shadow bit would never be read.
  logic [2:0]    sh;

  // Select, sample strobe and busy flag derived from the current state.
  always_comb begin
    busy   = (state == SCAN);
    sample = busy && (cnt == CNT_LAST);
    {sel1, sel2} = busy ? ch : 2'b00;
  end

  // Sweep sequencer: dwell counting, channel stepping, word assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ch     <= '0;
      cnt    <= '0;
      sh     <= '0;
      word   <= '0;
      done   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            ch    <= '0;
            cnt   <= '0;
          end
        end
        SCAN: begin
          if (sample) begin
            cnt <= '0;
            ch  <= ch + 2'd1;
            if (ch != 2'd3) begin
              sh[ch] <= y;
            end else begin
              word   <= {y, sh};
              done   <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
              parity <= ^{y, sh};
`endif
              if (!mode) state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
